// File: rtl/resize_accel_pkg.sv
// Shared helpers for the resize_accel multiplier: product width, saturation bounds
// and configuration legality.
package resize_accel_pkg;

  localparam int unsigned MUL_MAX_W = 62;

  function automatic int unsigned mul_prod_width(input int unsigned w0, input int unsigned w1);
    return w0 + w1;
  endfunction

  function automatic logic signed [63:0] mul_sat_max(input int unsigned width, input bit is_signed);
    if (is_signed) return (64'sd1 <<< (width - 1)) - 64'sd1;
    return (64'sd1 <<< width) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] mul_sat_min(input int unsigned width, input bit is_signed);
    if (is_signed) return -(64'sd1 <<< (width - 1));
    return 64'sd0;
  endfunction

  // Legal pipeline depth, shift range and a width the 64-bit bound math can hold.
  function automatic bit mul_cfg_ok(input int unsigned num_stage, input int unsigned shift,
                                    input int unsigned prod_w, input int unsigned dout_w);
    return (num_stage >= 3) && (num_stage <= 8) && (shift < prod_w) &&
           (prod_w + 1 <= MUL_MAX_W) && (dout_w >= 1) && (dout_w <= MUL_MAX_W);
  endfunction

endpackage

// File: rtl/resize_accel_mul_round_sat.sv
// Combinational round-half-up right shift followed by saturation to DOUT_WIDTH.
module resize_accel_mul_round_sat
  import resize_accel_pkg::*;
#(
  parameter int unsigned PROD_WIDTH = 24,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned DOUT_WIDTH = 24,
  parameter bit          RES_SIGNED = 1'b0
) (
  input  logic [PROD_WIDTH-1:0] prod,
  output logic [DOUT_WIDTH-1:0] dout_c,
  output logic                  sat_c
);

  localparam int unsigned XW = PROD_WIDTH + 1;
  localparam logic signed [XW-1:0] HALF = (SHIFT == 0) ? '0 : (XW'(1) << (SHIFT - 1));
  localparam logic signed [63:0] SAT_MAX = mul_sat_max(DOUT_WIDTH, RES_SIGNED);
  localparam logic signed [63:0] SAT_MIN = mul_sat_min(DOUT_WIDTH, RES_SIGNED);

  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] rnd;
  logic signed [XW-1:0] shifted;
  logic signed [63:0]   val;

  // One guard bit keeps the rounding add exact; the unsigned shift must clear it.
  always_comb begin
    if (RES_SIGNED) ext = $signed({prod[PROD_WIDTH-1], prod});
    else            ext = $signed({1'b0, prod});
    rnd = ext + HALF;
    if (RES_SIGNED) shifted = rnd >>> SHIFT;
    else            shifted = $signed(rnd >> SHIFT);
    val = 64'(shifted);
  end

  always_comb begin
    dout_c = val[DOUT_WIDTH-1:0];
    sat_c  = 1'b0;
    if (val > SAT_MAX) begin
      dout_c = SAT_MAX[DOUT_WIDTH-1:0];
      sat_c  = 1'b1;
    end else if (val < SAT_MIN) begin
      dout_c = SAT_MIN[DOUT_WIDTH-1:0];
      sat_c  = 1'b1;
    end
  end

endmodule

// File: rtl/resize_accel_mul_pipe.sv
// Fully pipelined multiplier with valid/ready, global stall, per-operand signedness,
// rounding shift, saturation and a sideband tag.
module resize_accel_mul_pipe
  import resize_accel_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH  = 12,
  parameter int unsigned DIN1_WIDTH  = 12,
  parameter int unsigned DOUT_WIDTH  = 24,
  parameter int unsigned NUM_STAGE   = 4,
  parameter bit          DIN0_SIGNED = 1'b0,
  parameter bit          DIN1_SIGNED = 1'b0,
  parameter int unsigned SHIFT       = 0,
  parameter int unsigned TAG_WIDTH   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_sat,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int unsigned P  = mul_prod_width(DIN0_WIDTH, DIN1_WIDTH);
  localparam int unsigned XW = P + 1;
  localparam int unsigned NV = NUM_STAGE - 1;
  localparam int unsigned ND = NUM_STAGE - 2;
  localparam bit RES_SIGNED  = DIN0_SIGNED | DIN1_SIGNED;

  if (!mul_cfg_ok(NUM_STAGE, SHIFT, P, DOUT_WIDTH)) begin : g_cfg_err
    $error("resize_accel_mul_pipe: illegal NUM_STAGE/SHIFT/width configuration");
  end

  logic                  adv;
  logic [DIN0_WIDTH-1:0] a_q;
  logic [DIN1_WIDTH-1:0] b_q;
  logic [NV-1:0]         vld_q;
  logic [TAG_WIDTH-1:0]  tag_q [NV];
  logic [P-1:0]          prod_q [ND];
  logic signed [XW-1:0]  a_x;
  logic signed [XW-1:0]  b_x;
  logic signed [XW-1:0]  prod_x;
  logic                  unused_prod_msb;
  logic [DOUT_WIDTH-1:0] rs_dout_c;
  logic                  rs_sat_c;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Extend each operand per its signedness; the low P bits hold the exact product.
  always_comb begin
    if (DIN0_SIGNED) a_x = XW'($signed(a_q));
    else             a_x = XW'(a_q);
    if (DIN1_SIGNED) b_x = XW'($signed(b_q));
    else             b_x = XW'(b_q);
    prod_x = a_x * b_x;
  end

  assign unused_prod_msb = prod_x[P];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= NV'({vld_q, in_valid});
    end
  end

  // Data path: operands (S1), product (S2), then pure delay up to S(NUM_STAGE-1).
  always_ff @(posedge clk) begin
    if (adv) begin
      a_q       <= din0;
      b_q       <= din1;
      tag_q[0]  <= in_tag;
      prod_q[0] <= prod_x[P-1:0];
      for (int i = 1; i < NV; i++) tag_q[i] <= tag_q[i-1];
      for (int i = 1; i < ND; i++) prod_q[i] <= prod_q[i-1];
    end
  end

  resize_accel_mul_round_sat #(
    .PROD_WIDTH (P),
    .SHIFT      (SHIFT),
    .DOUT_WIDTH (DOUT_WIDTH),
    .RES_SIGNED (RES_SIGNED)
  ) u_round_sat (
    .prod   (prod_q[ND-1]),
    .dout_c (rs_dout_c),
    .sat_c  (rs_sat_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      out_sat   <= 1'b0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= vld_q[NV-1];
      dout      <= rs_dout_c;
      out_sat   <= rs_sat_c;
      out_tag   <= tag_q[NV-1];
    end
  end

endmodule

// File: tb/tb_resize_accel_mul_pipe.sv
// Scoreboard bench for resize_accel_mul_pipe across five parameter sets.
module tb_resize_accel_mul_pipe;

  localparam int NI = 5;

  typedef struct {
    logic [23:0] dout;
    logic        sat;
    logic [7:0]  tag;
    int          due;
    bit          lat;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic [NI-1:0] iv;
  logic [NI-1:0] in_ready;
  logic [NI-1:0] ov;
  logic [NI-1:0] osat;
  logic [11:0]   din0;
  logic [11:0]   din1;
  logic [7:0]    in_tag;
  logic          out_ready;
  logic [23:0]   d0, d2, d3;
  logic [11:0]   d1;
  logic [15:0]   d4;
  logic [23:0]   dx [NI];
  logic [7:0]    otag [NI];

  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  exp_t exp_q [NI][$];
  exp_t mon_e;
  bit   held [NI];
  logic [23:0] hd [NI];
  logic [7:0]  htag [NI];
  logic        hsat [NI];
  bit   bp_done;
  int   va [8] = '{4095, 0, 2048, 2047, 123, 4095, 1000, 2};
  int   vb [8] = '{4095, 1, 2048, 4095, 456, 1, 3000, 3};
  logic [23:0] ed;
  logic        es;

  resize_accel_mul_pipe #(.TAG_WIDTH(8)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(in_ready[0]),
    .din0(din0), .din1(din1), .in_tag(in_tag), .out_valid(ov[0]), .out_ready(out_ready),
    .dout(d0), .out_sat(osat[0]), .out_tag(otag[0]));

  resize_accel_mul_pipe #(.DIN0_SIGNED(1'b1), .SHIFT(4), .DOUT_WIDTH(12), .TAG_WIDTH(8)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(in_ready[1]),
    .din0(din0), .din1(din1), .in_tag(in_tag), .out_valid(ov[1]), .out_ready(out_ready),
    .dout(d1), .out_sat(osat[1]), .out_tag(otag[1]));

  resize_accel_mul_pipe #(.SHIFT(2), .TAG_WIDTH(8)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(in_ready[2]),
    .din0(din0), .din1(din1), .in_tag(in_tag), .out_valid(ov[2]), .out_ready(out_ready),
    .dout(d2), .out_sat(osat[2]), .out_tag(otag[2]));

  resize_accel_mul_pipe #(.NUM_STAGE(3), .TAG_WIDTH(8)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[3]), .in_ready(in_ready[3]),
    .din0(din0), .din1(din1), .in_tag(in_tag), .out_valid(ov[3]), .out_ready(out_ready),
    .dout(d3), .out_sat(osat[3]), .out_tag(otag[3]));

  resize_accel_mul_pipe #(.NUM_STAGE(8), .DIN0_SIGNED(1'b1), .DIN1_SIGNED(1'b1), .SHIFT(3),
                          .DOUT_WIDTH(16), .TAG_WIDTH(8)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[4]), .in_ready(in_ready[4]),
    .din0(din0), .din1(din1), .in_tag(in_tag), .out_valid(ov[4]), .out_ready(out_ready),
    .dout(d4), .out_sat(osat[4]), .out_tag(otag[4]));

  assign dx[0] = d0;
  assign dx[1] = {{12{d1[11]}}, d1};
  assign dx[2] = d2;
  assign dx[3] = d3;
  assign dx[4] = {{8{d4[15]}}, d4};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic int nst(input int i);
    case (i)
      3:       return 3;
      4:       return 8;
      default: return 4;
    endcase
  endfunction

  // Reference: exact integer product, floor((p + half) / 2^sh), clamp to output range.
  function automatic void ref_mul(input int a, input int b, input bit s0, input bit s1,
                                  input int sh, input int dw,
                                  output logic [23:0] dv, output logic sat);
    longint pa, pb, r, mx, mn;
    pa = longint'(a & 4095);
    pb = longint'(b & 4095);
    if (s0 && pa >= 2048) pa = pa - 4096;
    if (s1 && pb >= 2048) pb = pb - 4096;
    r = pa * pb;
    if (sh > 0) r = (r + (longint'(1) << (sh - 1))) >>> sh;
    mx = (s0 || s1) ? (longint'(1) << (dw - 1)) - 1 : (longint'(1) << dw) - 1;
    mn = (s0 || s1) ? -(longint'(1) << (dw - 1)) : 0;
    sat = 1'b0;
    if (r > mx) begin
      r = mx;
      sat = 1'b1;
    end else if (r < mn) begin
      r = mn;
      sat = 1'b1;
    end
    dv = 24'(r);
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst%0d got %0h want %0h", name, i, got, want);
    end
  endtask

  // Present one operand pair until accepted, then queue its expected result.
  task automatic send(input int i, input int a, input int b, input int tag,
                      input logic [23:0] edv, input logic esat, input bit lat);
    exp_t e;
    bit   acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      @(negedge clk);
      iv = '0;
      iv[i] = 1'b1;
      din0 = 12'(a);
      din1 = 12'(b);
      in_tag = 8'(tag);
      #1;
      acc = in_ready[i];
      tries++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout inst%0d got in_ready 0 want 1", i);
    end else begin
      e.dout = edv;
      e.sat  = esat;
      e.tag  = 8'(tag);
      e.due  = edge_cnt + nst(i);
      e.lat  = lat;
      exp_q[i].push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      iv = '0;
    end
  endtask

  // Monitor: just before each rising edge, check handshake, hold and popped results.
  initial begin
    for (int i = 0; i < NI; i++) held[i] = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (reset_n) begin
        for (int i = 0; i < NI; i++) begin
          chk("in_ready_eq", i, 32'(in_ready[i]), 32'(!ov[i] | out_ready));
          if (held[i] && ov[i]) begin
            chk("hold_dout", i, 32'(dx[i]), 32'(hd[i]));
            chk("hold_sat", i, 32'(osat[i]), 32'(hsat[i]));
            chk("hold_tag", i, 32'(otag[i]), 32'(htag[i]));
          end
          held[i] = ov[i] && !out_ready;
          hd[i]   = dx[i];
          hsat[i] = osat[i];
          htag[i] = otag[i];
          if (ov[i] && out_ready) begin
            if (exp_q[i].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_out inst%0d got %0h want none", i, dx[i]);
            end else begin
              mon_e = exp_q[i].pop_front();
              chk("dout", i, 32'(dx[i]), 32'(mon_e.dout));
              chk("out_sat", i, 32'(osat[i]), 32'(mon_e.sat));
              chk("out_tag", i, 32'(otag[i]), 32'(mon_e.tag));
              if (mon_e.lat) chk("latency", i, 32'(edge_cnt), 32'(mon_e.due));
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b1;
    iv = '0;
    din0 = '0;
    din1 = '0;
    in_tag = '0;
    out_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_valid", i, 32'(ov[i]), 32'd0);
      chk("rst_ready", i, 32'(in_ready[i]), 32'd1);
      chk("rst_dout", i, 32'(dx[i]), 32'd0);
      chk("rst_sat", i, 32'(osat[i]), 32'd0);
      chk("rst_tag", i, 32'(otag[i]), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Default unsigned 12x12 -> 24
    send(0, 4095, 4095, 1, 24'd16769025, 1'b0, 1'b1);
    send(0, 0, 0, 2, 24'd0, 1'b0, 1'b1);
    send(0, 1, 4095, 3, 24'd4095, 1'b0, 1'b1);
    send(0, 2048, 2, 4, 24'd4096, 1'b0, 1'b1);

    // Signed x unsigned, SHIFT=4, 12-bit output
    send(1, 2048, 4095, 5, 24'hFFF800, 1'b1, 1'b1);
    send(1, 4093, 3, 6, 24'hFFFFFF, 1'b0, 1'b1);
    send(1, 2047, 4095, 7, 24'h0007FF, 1'b1, 1'b1);
    send(1, 5, 7, 8, 24'd2, 1'b0, 1'b1);
    send(1, 4091, 7, 9, 24'hFFFFFE, 1'b0, 1'b1);
    send(1, 4095, 8, 10, 24'd0, 1'b0, 1'b1);

    // Unsigned rounding, SHIFT=2
    send(2, 3, 1, 11, 24'd1, 1'b0, 1'b1);
    send(2, 2, 1, 12, 24'd1, 1'b0, 1'b1);
    send(2, 1, 1, 13, 24'd0, 1'b0, 1'b1);
    send(2, 4095, 4095, 14, 24'd4192256, 1'b0, 1'b1);

    // Depth sweep: NUM_STAGE=3 unsigned, NUM_STAGE=8 signed with shift/saturation
    for (int k = 0; k < 8; k++) begin
      ref_mul(va[k], vb[k], 1'b0, 1'b0, 0, 24, ed, es);
      send(3, va[k], vb[k], 20 + k, ed, es, 1'b1);
    end
    for (int k = 0; k < 8; k++) begin
      ref_mul(va[k], vb[k], 1'b1, 1'b1, 3, 16, ed, es);
      send(4, va[k], vb[k], 30 + k, ed, es, 1'b1);
    end
    idle(14);
    for (int i = 0; i < NI; i++) chk("drained", i, 32'(exp_q[i].size()), 32'd0);

    // Random backpressure on the default instance
    bp_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 20; k++) send(0, k, 1, k, 24'(k), 1'b0, 1'b0);
        @(negedge clk);
        iv = '0;
        bp_done = 1'b1;
      end
      begin
        for (int c = 0; c < 400 && !(bp_done && exp_q[0].size() == 0); c++) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(negedge clk);
    out_ready = 1'b1;
    idle(8);
    chk("bp_drained", 0, 32'(exp_q[0].size()), 32'd0);

    // Reset with a full, stalled pipeline
    for (int k = 0; k < 4; k++) send(0, 100 + k, 3, 40 + k, 24'(300 + 3 * k), 1'b0, 1'b0);
    @(negedge clk);
    iv = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("stall_valid", 0, 32'(ov[0]), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_valid", 0, 32'(ov[0]), 32'd0);
    chk("arst_ready", 0, 32'(in_ready[0]), 32'd1);
    chk("arst_dout", 0, 32'(dx[0]), 32'd0);
    exp_q[0].delete();
    #1 reset_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      #1;
      chk("no_stale", 0, 32'(ov[0]), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/resize_accel_mul_pipe.md
# resize_accel_mul_pipe

Parametrised, fully pipelined multiplier with a valid/ready handshake, per-operand signedness, a rounding right shift and output saturation. It is the general successor to the fixed 12x12 unsigned multiplier cores used in `resize_accel`. Interpolation datapaths instantiate it directly for fixed-point coefficient × pixel products. Backpressure stalls the whole pipeline, and a sideband tag travels with each product.

## Interface
- `DIN0_WIDTH`, 12, width of operand `din0`
- `DIN1_WIDTH`, 12, width of operand `din1`
- `DOUT_WIDTH`, 24, width of result `dout`
- `NUM_STAGE`, 4, pipeline latency in cycles, legal range 3..8
- `DIN0_SIGNED`, 0, 1 = `din0` is two's complement
- `DIN1_SIGNED`, 0, 1 = `din1` is two's complement
- `SHIFT`, 0, right shift applied to the product, 0..DIN0_WIDTH+DIN1_WIDTH-1
- `TAG_WIDTH`, 1, sideband width
- `clk`  in  1  clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operands valid
- `in_ready`  out  1  block accepts operands this cycle
- `din0`  in  DIN0_WIDTH  operand 0
- `din1`  in  DIN1_WIDTH  operand 1
- `in_tag`  in  TAG_WIDTH  sideband, passed through unchanged
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts the result
- `dout`  out  DOUT_WIDTH  rounded, saturated product
- `out_sat`  out  1  `dout` was clipped
- `out_tag`  out  TAG_WIDTH  tag of this result

## Operation
- Product width P = DIN0_WIDTH+DIN1_WIDTH.
- Each operand is sign- or zero-extended per its `*_SIGNED` parameter, then a full-precision P-bit product is formed.
- The result is signed if either operand is signed; otherwise it is unsigned.
- Rounding for SHIFT>0: add 2^(SHIFT-1), then arithmetic or logical shift right by SHIFT, i.e. round half up toward +inf. Intermediate values are one bit wider than P so the rounding add cannot overflow.
- When SHIFT=0, no rounding is applied.
- Saturation: if the shifted value does not fit in DOUT_WIDTH, clamp to the maximum or minimum of the DOUT_WIDTH type and set `out_sat`=1. Otherwise sign- or zero-extend or pass through, with `out_sat`=0.
- With defaults the block computes exactly the unsigned 12x12→24 product with 4-cycle latency.
- Handshake: a transfer occurs on a cycle where valid and ready are both high.
- `adv` = !`out_valid` | `out_ready`. `in_ready` = `adv`, combinational. No path exists from `in_valid` to `in_ready`.
- All stage registers, including a per-stage valid bit and the tag, load only when `adv`=1.
- When `adv`=0 every stage holds its contents, so bubbles are not collapsed.
- `dout`, `out_sat` and `out_tag` are held stable while `out_valid`=1 and `out_ready`=0.
- Stage mapping:
  - S1 registers operands.
  - S2 multiplies.
  - S3..S(NUM_STAGE-1) are pure delay registers, absorbed by DSP retiming.
  - The last stage performs round, shift and saturate.
  - When NUM_STAGE=3, S2 also feeds the final stage directly.

## Timing
- Reset (asserted asynchronously): all stage valid bits become 0. `out_valid`=0, `dout`=0, `out_sat`=0, `out_tag`=0, so `in_ready`=1 immediately.
- Data registers need not be reset; only the valid bits and outputs are reset.
- Reset during operation discards all in-flight results. No partial output appears after deassertion.
- Latency: an operand accepted at edge k appears on `out_valid` after edge k+NUM_STAGE-1, i.e. NUM_STAGE register stages, provided there is no stall.
- Throughput: 1 result per cycle while `out_ready`=1.
- Stall: each cycle with `out_valid`=1 and `out_ready`=0 adds exactly one cycle to the latency of every in-flight item. No item is dropped or duplicated.
- Simultaneous accept and emit in one cycle is legal and required for full throughput.

## Structure
- Shared package `resize_accel_pkg`: function `mul_sat_max(width, signed)` / `mul_sat_min`, the localparam for P, and the legal-range checks for NUM_STAGE and SHIFT (elaboration-time assertion).
- One sub-module, `resize_accel_mul_round_sat`: the combinational round, shift and saturate stage, parametrised by P, SHIFT, DOUT_WIDTH and signedness. It is verified stand-alone.
- The top level holds the valid/tag shift chain and the operand and product registers.

## Test plan
- Defaults, din0=4095, din1=4095, `out_ready`=1 → `dout`=16769025 four cycles later, `out_sat`=0.
- DIN0_SIGNED=1, DIN1_SIGNED=0, SHIFT=4, DOUT_WIDTH=12:
  - din0=-2048, din1=4095 → product -8386560. Shifted value -524160 saturates → `dout`=-2048, `out_sat`=1.
  - din0=-3, din1=3 → `dout`=-1 (-9+8=-1, >>4 = -1), `out_sat`=0.
- Rounding, unsigned, SHIFT=2: din0=3, din1=1 → `dout`=1. din0=2, din1=1 → `dout`=1 (half rounds up). din0=1, din1=1 → `dout`=0.
- Backpressure: stream 0..19 into din0 with din1=1, tags 0..19. Drive `out_ready` with a random 50% pattern → outputs appear in order, each exactly once, and are stable during stalls. `in_ready` equals !`out_valid`|`out_ready` on every cycle.
- Reset during operation: fill the pipeline with 4 items, deassert `out_ready`, pulse `reset_n` low between clock edges → `out_valid` drops to 0 asynchronously and `in_ready`=1. No stale result appears afterwards.
- Parameter sweep NUM_STAGE ∈ {3,8} with random operands → latency equals NUM_STAGE and every result matches the reference model bit for bit.
